// File: rtl/mte_arbiter.sv
// Two-requester round-robin front end for a fixed-latency MTE engine; one job in flight.
// Optional build macro MTE_ARB_KEYCHECK_EN reports an invalid engine key on resp_err.
module mte_arbiter #(
  parameter int N   = 256,
  parameter int LAT = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [N-1:0] req0_key,
  input  logic [N-1:0] req1_key,
  input  logic [N-1:0] req0_data,
  input  logic [N-1:0] req1_data,
  input  logic         req0_sel,
  input  logic         req1_sel,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_data,
  output logic         resp_id,
  output logic         resp_err,
  output logic [N-1:0] eng_key,
  output logic [N-1:0] eng_in,
  output logic         eng_sel,
  input  logic [N-1:0] eng_out,
  input  logic         eng_valid_key
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(LAT);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       rr_ptr;   // 1 = req1 has priority on a tie
  logic       grant0;
  logic       grant1;
  logic       capture;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  // Ready is also gated by reset_n so both readies read 0 while reset is held.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_IDLE && reset_n) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign capture    = (state == ST_BUSY) && (cnt == 4'd1);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      rr_ptr     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= 1'b0;
      eng_key    <= '0;
      eng_in     <= '0;
      eng_sel    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant0 || grant1) begin
            eng_key <= grant1 ? req1_key  : req0_key;
            eng_in  <= grant1 ? req1_data : req0_data;
            eng_sel <= grant1 ? req1_sel  : req0_sel;
            resp_id <= grant1;
            cnt     <= LAT_LOAD;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (capture) begin
            resp_data  <= eng_out;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            rr_ptr     <= ~resp_id;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MTE_ARB_KEYCHECK_EN
  logic err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= ~eng_valid_key;
    end
  end

  assign resp_err = err_q;
`else
  logic unused_valid_key;

  assign unused_valid_key = eng_valid_key;
  assign resp_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mte_arbiter.sv
// Directed bench for mte_arbiter with a combinational MTE engine stand-in.
module tb_mte_arbiter;

  localparam int N   = 256;
  localparam int LAT = 4;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_key, req1_key, req0_data, req1_data;
  logic         req0_sel, req1_sel;
  logic         resp_valid, resp_ready;
  logic [N-1:0] resp_data;
  logic         resp_id, resp_err;
  logic [N-1:0] eng_key, eng_in, eng_out;
  logic         eng_sel, eng_valid_key;

  int n_checks = 0;
  int n_fail   = 0;

  mte_arbiter #(.N(N), .LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_key(req0_key), .req1_key(req1_key),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_sel(req0_sel), .req1_sel(req1_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_err(resp_err),
    .eng_key(eng_key), .eng_in(eng_in), .eng_sel(eng_sel),
    .eng_out(eng_out), .eng_valid_key(eng_valid_key)
  );

  always #5 clock = ~clock;

  // Invertible toy cipher standing in for the MTE core.
  function automatic logic [N-1:0] mte_model(input logic [N-1:0] k, input logic [N-1:0] d,
                                             input logic s);
    logic [N-1:0] c;
    c = {8{32'hA5C3_0F96}};
    return s ? ((d ^ c) + k) : ((d - k) ^ c);
  endfunction

  assign eng_out = mte_model(eng_key, eng_in, eng_sel);

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, N'(resp_valid), '0);
    chk({tag, "_resp_data"},  resp_data,      '0);
    chk({tag, "_resp_id"},    N'(resp_id),    '0);
    chk({tag, "_resp_err"},   N'(resp_err),   '0);
    chk({tag, "_eng_key"},    eng_key,        '0);
    chk({tag, "_eng_in"},     eng_in,         '0);
    chk({tag, "_eng_sel"},    N'(eng_sel),    '0);
    chk({tag, "_readies"},    N'({req1_ready, req0_ready}), '0);
  endtask

  // Runs one job from grant to response handshake; requester valids are set by the caller.
  task automatic serve(input logic id, input logic [N-1:0] k, input logic [N-1:0] d,
                       input logic s, input logic bad_key, input int hold);
    logic [N-1:0] exp_data;
    logic         exp_err;
    exp_data = mte_model(k, d, s);
`ifdef MTE_ARB_KEYCHECK_EN
    exp_err = bad_key;
`else
    exp_err = 1'b0;
`endif
    eng_valid_key = ~bad_key;
    #1;
    chk("grant", N'({req1_ready, req0_ready}), id ? N'(2'b10) : N'(2'b01));
    step();
    chk("eng_key", eng_key, k);
    chk("eng_in", eng_in, d);
    chk("eng_sel", N'(eng_sel), N'(s));
    chk("busy_readies", N'({req1_ready, req0_ready}), '0);
    for (int i = 1; i < LAT; i++) begin
      step();
      chk("busy_no_resp", N'(resp_valid), '0);
    end
    step();
    chk("resp_valid", N'(resp_valid), N'(1'b1));
    chk("resp_data", resp_data, exp_data);
    chk("resp_id", N'(resp_id), N'(id));
    chk("resp_err", N'(resp_err), N'(exp_err));
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      step();
      chk("hold_valid", N'(resp_valid), N'(1'b1));
      chk("hold_data", resp_data, exp_data);
      chk("hold_id", N'(resp_id), N'(id));
      chk("hold_err", N'(resp_err), N'(exp_err));
      chk("hold_readies", N'({req1_ready, req0_ready}), '0);
    end
    resp_ready = 1'b1;
    step();
    chk("resp_done", N'(resp_valid), '0);
    resp_ready    = 1'b0;
    eng_valid_key = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    req0_valid    = 1'b1;
    req1_valid    = 1'b0;
    req0_key      = '0;
    req0_data     = N'(1);
    req0_sel      = 1'b1;
    req1_key      = '0;
    req1_data     = '0;
    req1_sel      = 1'b0;
    resp_ready    = 1'b0;
    eng_valid_key = 1'b1;

    // Reset state, with req0 already requesting
    #2;
    chk_all_zero("reset");
    step();
    step();
    reset_n = 1'b1;

    // Single job: key 0, data 1, encrypt
    serve(1'b0, '0, N'(1), 1'b1, 1'b0, 0);
    req0_valid = 1'b0;

    // Reset pulse, then simultaneous requests
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset2");
    step();
    reset_n    = 1'b1;
    req0_key   = N'(256'h1111);
    req0_data  = N'(256'hABCD);
    req0_sel   = 1'b1;
    req1_key   = N'(256'h2222);
    req1_data  = N'(256'h5A5A);
    req1_sel   = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    serve(1'b0, req0_key, req0_data, req0_sel, 1'b0, 0);
    serve(1'b1, req1_key, req1_data, req1_sel, 1'b0, 0);

    // Fairness over six jobs, with backpressure on the third
    for (int j = 0; j < 6; j++) begin
      if (j[0]) serve(1'b1, req1_key, req1_data, req1_sel, 1'b0, 0);
      else      serve(1'b0, req0_key, req0_data, req0_sel, 1'b0, (j == 2) ? 3 : 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Key check on req1 with an invalid engine key
    req1_key   = N'(8'hF);
    req1_data  = N'(8'h2);
    req1_sel   = 1'b0;
    req1_valid = 1'b1;
    serve(1'b1, req1_key, req1_data, req1_sel, 1'b1, 0);
    req1_valid = 1'b0;

    // Idle with no requesters: nothing issued, engine drive retained
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_no_resp", N'(resp_valid), '0);
      chk("idle_readies", N'({req1_ready, req0_ready}), '0);
    end
    chk("idle_eng_key", eng_key, N'(8'hF));
    chk("idle_eng_in", eng_in, N'(8'h2));

    // Reset two cycles into BUSY aborts the job
    req0_key   = N'(256'h77);
    req0_data  = N'(256'h99);
    req0_sel   = 1'b1;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    chk("abort_accept", eng_in, N'(256'h99));
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk_all_zero("busy_reset");
    step();
    reset_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      step();
      chk("abort_no_resp", N'(resp_valid), '0);
    end

    // Next req1 job completes normally
    req1_key   = N'(256'h3C3C);
    req1_data  = N'(256'hF00D);
    req1_sel   = 1'b1;
    req1_valid = 1'b1;
    serve(1'b1, req1_key, req1_data, req1_sel, 1'b0, 0);
    req1_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
